// File: rtl/regfile_mp.sv
// regfile_mp: one-write / NREAD-read register file with a hard-wired zero register at DEPTH-1.
// Build option: define REGFILE_MP_BYPASS_EN for same-cycle write-through to colliding reads.
module regfile_mp #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [AW-1:0]                WriteRegister,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [NREAD-1:0]             ReadEn,
  input  logic [NREAD-1:0][AW-1:0]     ReadRegister,
  output logic [NREAD-1:0][WIDTH-1:0]  ReadData,
  output logic [NREAD-1:0]             ReadValid
);

  localparam logic [AW-1:0] ZREG = AW'(DEPTH - 1);

  // Only DEPTH-1 physical entries; the zero register and any address beyond it decode to nothing.
  logic [WIDTH-1:0] mem_reg [DEPTH-1];
  logic             wr_ok;

  assign wr_ok = RegWrite && (WriteRegister < ZREG);

  // Flops rather than RAM: reset must clear every entry asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH - 1; e++) mem_reg[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH - 1; e++) begin
        if (wr_ok && (WriteRegister == AW'(e))) mem_reg[e] <= WriteData;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
      logic [WIDTH-1:0] rd_word;
      logic [WIDTH-1:0] rdata_reg;
      logic             valid_reg;

      // Decoded mux: unmatched addresses (zero register, out of range) fall through to 0.
      always_comb begin
        rd_word = '0;
        for (int e = 0; e < DEPTH - 1; e++) begin
          if (ReadRegister[gi] == AW'(e)) rd_word = mem_reg[e];
        end
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_ok && (WriteRegister == ReadRegister[gi])) rd_word = WriteData;
`endif
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= ReadEn[gi];
          if (ReadEn[gi]) rdata_reg <= rd_word;
        end
      end

      assign ReadData[gi]  = rdata_reg;
      assign ReadValid[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model.
// Covers both builds; expected collision data follows REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             we;
  logic [4:0]       wa;
  logic [63:0]      wd;
  logic [1:0]       ren;
  logic [1:0][4:0]  ra;
  logic [1:0][63:0] rdata;
  logic [1:0]       rvalid;

  logic             p_we;
  logic [3:0]       p_wa;
  logic [15:0]      p_wd;
  logic [2:0]       p_ren;
  logic [2:0][3:0]  p_ra;
  logic [2:0][15:0] p_rd;
  logic [2:0]       p_rv;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents plus what each port should currently show.
  logic [63:0] m_mem [32];
  logic [63:0] m_rd  [2];
  logic        m_rv  [2];

  regfile_mp dut (
    .clk(clk), .reset(rst), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadEn(ren), .ReadRegister(ra), .ReadData(rdata), .ReadValid(rvalid)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(12), .NREAD(3)) dut_p (
    .clk(clk), .reset(rst), .RegWrite(p_we), .WriteRegister(p_wa), .WriteData(p_wd),
    .ReadEn(p_ren), .ReadRegister(p_ra), .ReadData(p_rd), .ReadValid(p_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = '0;
      m_rv[p] = 1'b0;
    end
  endtask

  // Advance one clock edge and apply the register-file rules to the model.
  task automatic step();
    logic [63:0] nrd [2];
    logic        nrv [2];
    for (int p = 0; p < 2; p++) begin
      if (ren[p]) begin
        if (ra[p] >= 5'd31)                      nrd[p] = '0;
        else if (BYPASS && we && wa == ra[p])    nrd[p] = wd;
        else                                     nrd[p] = m_mem[ra[p]];
      end else begin
        nrd[p] = m_rd[p];
      end
      nrv[p] = ren[p];
    end
    if (we && wa < 5'd31) m_mem[wa] = wd;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = nrd[p];
      m_rv[p] = nrv[p];
    end
  endtask

  task automatic test_reset();
    #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rdata[p] !== 64'd0 || rvalid[p] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_initial port %0d: got data %h valid %b, expected 0/0", p, rdata[p], rvalid[p]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 31; i++) begin
      we = 1'b1; wa = 5'(i); wd = {$urandom(), $urandom()} | 64'd1;
      step();
    end
    we = 1'b0; ren = 2'b11; ra[0] = 5'd3; ra[1] = 5'd4;
    step();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rdata[p] !== m_rd[p] || rvalid[p] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_preload port %0d: got %h/%b, expected %h/1", p, rdata[p], rvalid[p], m_rd[p]);
      end
    end
    // Assert reset between edges with a write and reads still requested.
    we = 1'b1; wa = 5'd0; wd = 64'hFFFF_0000_FFFF_0000;
    #2; rst = 1'b1; #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rdata[p] !== 64'd0 || rvalid[p] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_async port %0d: got %h/%b, expected 0/0", p, rdata[p], rvalid[p]);
      end
    end
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rdata[p] !== 64'd0 || rvalid[p] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held port %0d: got %h/%b, expected 0/0", p, rdata[p], rvalid[p]);
      end
    end
    rst = 1'b0;
    m_reset();
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ren = 2'b11; ra[0] = 5'(2 * i); ra[1] = 5'(2 * i + 1);
      step();
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (rdata[p] !== 64'd0 || rvalid[p] !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_cleared entry %0d: got %h/%b, expected 0/1", ra[p], rdata[p], rvalid[p]);
        end
      end
    end
    ren = 2'b00;
    step();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wd = 64'hDEADBEEF_01234567; ren = 2'b00;
    step();
    we = 1'b0; ren = 2'b01; ra[0] = 5'd5;
    step();
    vectors++;
    if (rdata[0] !== 64'hDEADBEEF_01234567 || rvalid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL write_read: got %h/%b, expected deadbeef01234567/1", rdata[0], rvalid[0]);
    end
    ren = 2'b00;
    step();
    vectors++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 64'hDEADBEEF_01234567) begin
      miscompares++;
      $display("FAIL write_read_pulse: got %h/%b, expected deadbeef01234567/0", rdata[0], rvalid[0]);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd31; wd = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    we = 1'b0; ren = 2'b11; ra[0] = 5'd31; ra[1] = 5'd31;
    step();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rdata[p] !== 64'd0 || rvalid[p] !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_reg port %0d: got %h/%b, expected 0/1", p, rdata[p], rvalid[p]);
      end
    end
    ren = 2'b00;
  endtask

  task automatic test_collision();
    logic [63:0] exp_coll;
    exp_coll = BYPASS ? 64'h22 : 64'h11;
    we = 1'b1; wa = 5'd7; wd = 64'h11; ren = 2'b00;
    step();
    wd = 64'h22; ren = 2'b10; ra[1] = 5'd7;
    step();
    vectors++;
    if (rdata[1] !== exp_coll || rvalid[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision: got %h/%b, expected %h/1", rdata[1], rvalid[1], exp_coll);
    end
    we = 1'b0;
    step();
    vectors++;
    if (rdata[1] !== 64'h22) begin
      miscompares++;
      $display("FAIL collision_after: got %h, expected 22", rdata[1]);
    end
    ren = 2'b00;
  endtask

  task automatic test_hold();
    we = 1'b1; wa = 5'd9; wd = 64'hAB;
    step();
    we = 1'b0; ren = 2'b01; ra[0] = 5'd9;
    step();
    ren = 2'b00;
    for (int c = 0; c < 3; c++) begin
      ra[0] = 5'($urandom_range(0, 31));
      step();
      vectors++;
      if (rdata[0] !== 64'hAB || rvalid[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cycle %0d: got %h/%b, expected ab/0", c, rdata[0], rvalid[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we  = 1'($urandom());
      wa  = 5'($urandom_range(0, 31));
      wd  = {$urandom(), $urandom()};
      ren = 2'($urandom());
      for (int p = 0; p < 2; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step();
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (rdata[p] !== m_rd[p] || rvalid[p] !== m_rv[p]) begin
          miscompares++;
          $display("FAIL random cycle %0d port %0d: got %h/%b, expected %h/%b",
                   c, p, rdata[p], rvalid[p], m_rd[p], m_rv[p]);
        end
      end
    end
    we = 1'b0; ren = 2'b00;
  endtask

  task automatic test_param();
    logic [15:0] exp_p;
    int a;
    p_we = 1'b1; p_wa = 4'd3; p_wd = 16'hBEEF;
    step();
    p_wa = 4'd14; p_wd = 16'h1234;
    step();
    p_wa = 4'd11; p_wd = 16'h5555;
    step();
    p_we = 1'b0; p_ren = 3'b111; p_ra[0] = 4'd3; p_ra[1] = 4'd3; p_ra[2] = 4'd11;
    step();
    for (int p = 0; p < 3; p++) begin
      exp_p = (p < 2) ? 16'hBEEF : 16'h0000;
      vectors++;
      if (p_rd[p] !== exp_p || p_rv[p] !== 1'b1) begin
        miscompares++;
        $display("FAIL param_concurrent port %0d: got %h/%b, expected %h/1", p, p_rd[p], p_rv[p], exp_p);
      end
    end
    // Scan every encodable address: only entry 3 may be nonzero.
    for (int g = 0; g < 6; g++) begin
      for (int p = 0; p < 3; p++) begin
        a = (3 * g + p > 15) ? 15 : 3 * g + p;
        p_ra[p] = 4'(a);
      end
      step();
      for (int p = 0; p < 3; p++) begin
        exp_p = (p_ra[p] == 4'd3) ? 16'hBEEF : 16'h0000;
        vectors++;
        if (p_rd[p] !== exp_p || p_rv[p] !== 1'b1) begin
          miscompares++;
          $display("FAIL param_scan addr %0d: got %h/%b, expected %h/1", p_ra[p], p_rd[p], p_rv[p], exp_p);
        end
      end
    end
    p_ren = 3'b000;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ren = '0; ra = '0;
    p_we = 1'b0; p_wa = '0; p_wd = '0; p_ren = '0; p_ra = '0;
    m_reset();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_collision();
    test_hold();
    test_param();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
